// File: rtl/gate_response_checker_pkg.sv
// Shared types and truth-table constants for the gate response checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Expected-output tables, bit i = gate output for input vector i.
    localparam logic [1:0] TT_NOT = 2'b01;
    localparam logic [3:0] TT_AND = 4'b1000;
    localparam logic [3:0] TT_OR  = 4'b1110;
    localparam logic [3:0] TT_XOR = 4'b0110;

endpackage

// File: rtl/gate_response_checker_if.sv
// Sample/result bundle between a stimulus source (master) and the checker (slave).
interface gate_response_checker_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 8
) ();

    logic                 start;
    logic                 smp_valid;
    logic [N_IN-1:0]      smp_vec;
    logic                 smp_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_cnt;
    logic [ERR_W-1:0]     smp_cnt;
    logic [2**N_IN-1:0]   cov_map;
    logic                 first_fail_v;
    logic [N_IN-1:0]      first_fail;

    modport master (
        output start, smp_valid, smp_vec, smp_out,
        input  busy, done, pass, err_cnt, smp_cnt, cov_map, first_fail_v, first_fail
    );

    modport slave (
        input  start, smp_valid, smp_vec, smp_out,
        output busy, done, pass, err_cnt, smp_cnt, cov_map, first_fail_v, first_fail
    );

endinterface

// File: rtl/gate_response_checker_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/gate_response_checker.sv
// Compares observed gate outputs against a truth table, tracking coverage,
// mismatch count and the first failing input vector.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int                  N_IN        = 2,
    parameter logic [2**N_IN-1:0]  TRUTH_TABLE = 4'b1000,
    parameter int                  ERR_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    gate_response_checker_if.slave chk
);

    localparam int N_VEC = 2**N_IN;

    state_t            state_q, state_d;
    logic [N_VEC-1:0]  cov_map_q, cov_map_d;
    logic              first_fail_v_q, first_fail_v_d;
    logic [N_IN-1:0]   first_fail_q, first_fail_d;
    logic              pass_q, pass_d;
    logic              accept;
    logic              exp_bit;
    logic              mismatch;

    // A start pulse takes priority over a coincident sample, which is dropped.
    always_comb begin
        accept   = (state_q == RUN) && chk.smp_valid && !chk.start;
        exp_bit  = TRUTH_TABLE[chk.smp_vec];
        mismatch = accept && (chk.smp_out !== exp_bit);
    end

    always_comb begin
        state_d        = state_q;
        cov_map_d      = cov_map_q;
        first_fail_v_d = first_fail_v_q;
        first_fail_d   = first_fail_q;
        pass_d         = pass_q;
        if (chk.start) begin
            state_d        = RUN;
            cov_map_d      = '0;
            first_fail_v_d = 1'b0;
            first_fail_d   = '0;
            pass_d         = 1'b0;
        end else if (accept) begin
            cov_map_d[chk.smp_vec] = 1'b1;
            if (mismatch && !first_fail_v_q) begin
                first_fail_v_d = 1'b1;
                first_fail_d   = chk.smp_vec;
            end
            // The completing sample's own mismatch must already count against pass.
            if (&cov_map_d) begin
                state_d = DONE;
                pass_d  = (chk.err_cnt == '0) && !mismatch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cov_map_q      <= '0;
            first_fail_v_q <= 1'b0;
            first_fail_q   <= '0;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cov_map_q      <= cov_map_d;
            first_fail_v_q <= first_fail_v_d;
            first_fail_q   <= first_fail_d;
            pass_q         <= pass_d;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (chk.start),
        .inc (mismatch),
        .cnt (chk.err_cnt)
    );

    sat_counter #(.W(ERR_W)) u_smp_cnt (
        .clk (clk),
        .rst (rst),
        .clr (chk.start),
        .inc (accept),
        .cnt (chk.smp_cnt)
    );

    assign chk.busy         = (state_q == RUN);
    assign chk.done         = (state_q == DONE);
    assign chk.pass         = pass_q;
    assign chk.cov_map      = cov_map_q;
    assign chk.first_fail_v = first_fail_v_q;
    assign chk.first_fail   = first_fail_q;

endmodule
